est_interp_ctrl: RTL and testbench

EST_INTERP_CTRL -- requirements
Module: est_interp_ctrl

---
 rtl/est_interp_ctrl.sv | 153 +++++++++++++++
 tb/tb_est_interp_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/est_interp_ctrl.sv
// ---------------------------------------------------------------------------
// est_interp_ctrl
//
// Sequencer for the channel-estimate interpolator of one slot. On a start it
// latches the slot parity and the reduced NRS frequency shift. It then walks
// every (subcarrier, symbol) pair of the resource block, sc fastest, emitting
// one beat per pair. Each beat carries the frequency weight index and the
// estimate-pair swap select. Beats advance only when the downstream side
// accepts them (out_valid & dn_ready).
//
// Optional feature: define INTERP_ABORT_EN to add an 'abort' input that
// abandons a slot in progress and returns to IDLE with counters cleared.
// ---------------------------------------------------------------------------
module est_interp_ctrl #(
  parameter int NUM_SC  = 12,
  parameter int NUM_SYM = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] nrs_vshift,
  input  logic       slot_odd,
  input  logic       dn_ready,
`ifdef INTERP_ABORT_EN
  input  logic       abort,
`endif
  output logic       mux_sel,
  output logic [3:0] sc_idx,
  output logic [2:0] sym_idx,
  output logic [1:0] w_freq,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       start_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SC_LAST  = 4'(NUM_SC - 1);
  localparam logic [2:0] SYM_LAST = 3'(NUM_SYM - 1);

  // First symbol index that carries NRS; the estimate pair swaps from here on.
  localparam logic [2:0] NRS_SYM_FIRST = 3'd5;

  state_t     state_q, state_d;
  logic [3:0] sc_q;
  logic [2:0] sym_q;
  logic [2:0] vshift_q;
  logic       odd_q;
  logic       err_q;
  logic [2:0] vshift_red;
  logic       abort_run;
  logic       accept;
  logic       last_beat;
  logic [4:0] wsum;

`ifdef INTERP_ABORT_EN
  assign abort_run = (state_q == RUN) && abort;
`else
  assign abort_run = 1'b0;
`endif

  // In RUN out_valid is always high, so a beat is accepted whenever dn_ready is.
  assign accept    = (state_q == RUN) && dn_ready;
  assign last_beat = accept && (sc_q == SC_LAST) && (sym_q == SYM_LAST);

  // Fold the cell-ID-mod-6 shift into 0..5 (6 and 7 alias onto 0 and 1).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    vshift_red = nrs_vshift;
    case (nrs_vshift)
      3'd6:    vshift_red = 3'd0;
      3'd7:    vshift_red = 3'd1;
      default: vshift_red = nrs_vshift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values of its peers, matching the hardware.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: abort beats a simultaneous last beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort_run)      state_d = IDLE;
        else if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat counters, latched slot configuration and the sticky start error.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q     <= '0;
      sym_q    <= '0;
      vshift_q <= '0;
      odd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (start) begin
          vshift_q <= vshift_red;
          odd_q    <= slot_odd;
          sc_q     <= '0;
          sym_q    <= '0;
        end
      end else if (state_q == RUN) begin
        if (abort_run) begin
          sc_q  <= '0;
          sym_q <= '0;
        end else if (accept) begin
          if (sc_q == SC_LAST) begin
            sc_q  <= '0;
            sym_q <= (sym_q == SYM_LAST) ? 3'd0 : sym_q + 3'd1;
          end else begin
            sc_q <= sc_q + 4'd1;
          end
        end
      end
      // A start outside IDLE is dropped but remembered until reset.
      if (start && (state_q != IDLE)) err_q <= 1'b1;
    end
  end

  // Outputs: decoded from the registered state only.
  always_comb begin
    // Adding 6 keeps the sum non-negative for any vshift in 0..5.
    wsum      = 5'(sc_q) + 5'd6 - 5'(vshift_q);
    w_freq    = 2'(wsum % 5'd3);
    mux_sel   = odd_q ^ (sym_q >= NRS_SYM_FIRST);
    sc_idx    = sc_q;
    sym_idx   = sym_q;
    out_valid = (state_q == RUN);
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    start_err = err_q;
  end

endmodule

// File: tb/tb_est_interp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_est_interp_ctrl
//
// Bench for est_interp_ctrl. A behavioural model tracks the slot as a beat
// number 0..NUM_SC*NUM_SYM-1 and derives sc, sym, weight and swap select from
// it arithmetically. A negedge process compares every DUT output to the model
// each cycle. Directed slots pin the model with literal values; randomized
// slots vary shift, parity, backpressure, stray starts and resets.
// Optional: INTERP_ABORT_EN also exercises the abort port.
// ---------------------------------------------------------------------------
module tb_est_interp_ctrl;

  localparam int NUM_SC  = 12;
  localparam int NUM_SYM = 7;
  localparam int TOTAL   = NUM_SC * NUM_SYM;
`ifdef INTERP_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] nrs_vshift = 3'd0;
  logic       slot_odd = 1'b0;
  logic       dn_ready = 1'b0;
  logic       abort = 1'b0;
  logic       abort_eff;
  logic       mux_sel, out_valid, busy, done, start_err;
  logic [3:0] sc_idx;
  logic [2:0] sym_idx;
  logic [1:0] w_freq;

  assign abort_eff = ABORT_ON & abort;

  est_interp_ctrl #(.NUM_SC(NUM_SC), .NUM_SYM(NUM_SYM)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .nrs_vshift (nrs_vshift),
    .slot_odd   (slot_odd),
    .dn_ready   (dn_ready),
`ifdef INTERP_ABORT_EN
    .abort      (abort),
`endif
    .mux_sel    (mux_sel),
    .sc_idx     (sc_idx),
    .sym_idx    (sym_idx),
    .w_freq     (w_freq),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .start_err  (start_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_active = 1'b0;  // slot in progress
  bit m_done   = 1'b0;  // the cycle right after the final beat
  int m_n      = 0;     // index of the beat currently presented
  bit m_err    = 1'b0;
  int m_rv     = 0;     // cell shift reduced to 0..5
  bit m_odd    = 1'b0;

  always @(posedge clk) begin : model
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_n      <= 0;
      m_err    <= 1'b0;
      m_rv     <= 0;
      m_odd    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (start) m_err <= 1'b1;
        if (abort_eff) begin
          m_active <= 1'b0;
          m_n      <= 0;
        end else if (dn_ready) begin
          if (m_n + 1 == TOTAL) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_done   <= 1'b1;
          end else begin
            m_n <= m_n + 1;
          end
        end
      end else if (m_done) begin
        if (start) m_err <= 1'b1;
      end else if (start) begin
        m_active <= 1'b1;
        m_n      <= 0;
        m_rv     <= (int'(nrs_vshift) >= 6) ? int'(nrs_vshift) - 6 : int'(nrs_vshift);
        m_odd    <= slot_odd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    int sc_e, sym_e;
    if (chk_en) begin
      check("out_valid", out_valid, m_active);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("start_err", start_err, m_err);
      if (m_active) begin
        sc_e  = m_n % NUM_SC;
        sym_e = m_n / NUM_SC;
        check("sc_idx", sc_idx, sc_e);
        check("sym_idx", sym_idx, sym_e);
        check("w_freq", w_freq, (sc_e + 6 - m_rv) % 3);
        check("mux_sel", mux_sel, m_odd ^ (sym_e >= 5));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [3:0] log_sc  [TOTAL];
  logic [2:0] log_sym [TOTAL];
  logic [1:0] log_w   [TOTAL];
  logic       log_mux [TOTAL];
  logic [1:0] ref_w   [TOTAL];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one slot from IDLE and drive it. Modes: 0 dn_ready constant 1,
  // 1 dn_ready toggling 1,0,..., 2 random backpressure with stray starts and
  // aborts, 3 dn_ready 1 with a stray start during beat 10. Returns in the
  // done cycle, right after a reset at beat rst_at, or after an abort.
  task automatic run_slot(input logic [2:0] vs, input bit odd, input int mode,
                          input int rst_at, input int abort_at,
                          output int beats, output int run_cyc, output bit saw_done);
    beats = 0;
    run_cyc = 0;
    saw_done = 1'b0;
    nrs_vshift = vs;
    slot_odd = odd;
    start = 1'b1;
    dn_ready = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    // These must be ignored once the slot has started.
    nrs_vshift = 3'($urandom_range(0, 7));
    slot_odd = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 2000; cyc++) begin
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        saw_done = 1'b1;
        return;
      end
      if (!busy) return;
      case (mode)
        0, 3:    dn_ready = 1'b1;
        1:       dn_ready = (run_cyc % 2 == 0);
        default: dn_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 2) begin
        start = ($urandom_range(0, 39) == 0);
        abort = ($urandom_range(0, 199) == 0);
      end
      if (mode == 3) start = (beats == 10);
      if (beats == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        dn_ready = 1'b0;
        return;
      end
      if (beats == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        return;
      end
      if (dn_ready && beats < TOTAL) begin
        log_sc[beats]  = sc_idx;
        log_sym[beats] = sym_idx;
        log_w[beats]   = w_freq;
        log_mux[beats] = mux_sel;
      end
      if (dn_ready) beats++;
      run_cyc++;
      step();
    end
    check("slot_timeout", 0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b, rc, seen;
    bit sd;

    // Reset state.
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_sc", sc_idx, 0);
    check("rst_sym", sym_idx, 0);
    check("rst_mux", mux_sel, 0);
    rst = 1'b0;
    step();

    // vshift=2, even slot, no backpressure.
    run_slot(3'd2, 1'b0, 0, -1, -1, b, rc, sd);
    check("s1_beats", b, 84);
    check("s1_run_cycles", rc, 84);
    check("s1_done", sd, 1);
    check("s1_first_sc", log_sc[0], 0);
    check("s1_first_sym", log_sym[0], 0);
    check("s1_first_w", log_w[0], 1);
    check("s1_first_mux", log_mux[0], 0);
    check("s1_last_sc", log_sc[83], 11);
    check("s1_last_sym", log_sym[83], 6);
    step();
    check("s1_done_one_cycle", done, 0);

    // Odd slot, vshift=0: swap select per symbol, weights cycle 0,1,2.
    run_slot(3'd0, 1'b1, 0, -1, -1, b, rc, sd);
    check("s2_w0", log_w[0], 0);
    check("s2_w1", log_w[1], 1);
    check("s2_w2", log_w[2], 2);
    check("s2_w3", log_w[3], 0);
    check("s2_mux_sym0", log_mux[0], 1);
    check("s2_mux_sym4", log_mux[59], 1);
    check("s2_mux_sym5", log_mux[60], 0);
    check("s2_mux_sym6", log_mux[83], 0);
    step();

    // Toggling backpressure: 84 beats over 167 RUN cycles.
    run_slot(3'd5, 1'b0, 1, -1, -1, b, rc, sd);
    check("s3_beats", b, 84);
    check("s3_run_cycles", rc, 167);
    check("s3_done", sd, 1);
    step();

    // Stray start during beat 10: ignored, sequence intact, error sticky.
    run_slot(3'd4, 1'b0, 3, -1, -1, b, rc, sd);
    check("s4_beats", b, 84);
    check("s4_sc10", log_sc[10], 10);
    check("s4_sc12", log_sc[12], 0);
    check("s4_sym12", log_sym[12], 1);
    check("s4_err", start_err, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s4_err_cleared", start_err, 0);
    // Stray start in the done cycle.
    run_slot(3'd3, 1'b1, 0, -1, -1, b, rc, sd);
    check("s4b_done", sd, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("s4b_no_restart", busy, 0);
    check("s4b_err", start_err, 1);
    for (int i = 0; i < 5; i++) step();
    check("s4b_err_sticky", start_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // vshift=7 must weight exactly like vshift=1; then a reset at beat 40.
    run_slot(3'd1, 1'b0, 0, -1, -1, b, rc, sd);
    for (int i = 0; i < TOTAL; i++) ref_w[i] = log_w[i];
    step();
    run_slot(3'd7, 1'b0, 0, -1, -1, b, rc, sd);
    check("s5_w0_lit", log_w[0], 2);
    for (int i = 0; i < TOTAL; i++) check("s5_w_alias", log_w[i], ref_w[i]);
    step();
    run_slot(3'd7, 1'b1, 0, 40, -1, b, rc, sd);
    check("s5_rst_beats", b, 40);
    check("s5_rst_valid", out_valid, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_sc", sc_idx, 0);
    check("s5_rst_sym", sym_idx, 0);
    check("s5_rst_mux", mux_sel, 0);
    check("s5_rst_w", w_freq, 0);
    seen = 0;
    dn_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done) seen++;
      step();
    end
    check("s5_no_done", seen, 0);

`ifdef INTERP_ABORT_EN
    // Abort at beat 20, then a fresh slot from (0,0).
    run_slot(3'd3, 1'b1, 0, -1, 20, b, rc, sd);
    check("s6_abort_beats", b, 20);
    check("s6_abort_valid", out_valid, 0);
    check("s6_abort_sc", sc_idx, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) seen++;
      step();
    end
    check("s6_no_done", seen, 0);
    run_slot(3'd3, 1'b1, 0, -1, -1, b, rc, sd);
    check("s6_restart_sc", log_sc[0], 0);
    check("s6_restart_sym", log_sym[0], 0);
    check("s6_restart_beats", b, 84);
    step();
`endif

    // Randomized slots.
    for (int s = 0; s < 14; s++) begin
      int ra;
      ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TOTAL - 1)) : -1;
      run_slot(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2, ra, -1, b, rc, sd);
      if (sd) check("rand_beats", b, TOTAL);
      // Idle gap with random inputs that must have no effect.
      start = 1'b0;
      for (int i = 0; i <= int'($urandom_range(1, 4)); i++) begin
        dn_ready = 1'($urandom_range(0, 1));
        abort = 1'($urandom_range(0, 1));
        step();
      end
      abort = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
